// File: rtl/seg_serial_rx_pkg.sv
// Shared definitions for the serial 7-segment link receiver: glyph codes, FSM states, glyph decode.
// Segment bytes are active-low with bit7 = dp; the dp bit never takes part in decoding.
package seg_serial_rx_pkg;

    localparam logic [7:0] SEG_G0 = 8'hC0;
    localparam logic [7:0] SEG_G1 = 8'hF9;
    localparam logic [7:0] SEG_G2 = 8'hA4;
    localparam logic [7:0] SEG_G3 = 8'hB0;
    localparam logic [7:0] SEG_G4 = 8'h99;
    localparam logic [7:0] SEG_G5 = 8'h92;
    localparam logic [7:0] SEG_G6 = 8'h82;
    localparam logic [7:0] SEG_G7 = 8'hF8;
    localparam logic [7:0] SEG_G8 = 8'h80;
    localparam logic [7:0] SEG_G9 = 8'h90;
    localparam logic [7:0] SEG_GA = 8'h88;
    localparam logic [7:0] SEG_GB = 8'h83;
    localparam logic [7:0] SEG_GC = 8'hC6;
    localparam logic [7:0] SEG_GD = 8'hA1;
    localparam logic [7:0] SEG_GE = 8'h86;
    localparam logic [7:0] SEG_GF = 8'h8E;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Returns {err, hex}; a blank or unknown pattern yields err=1, hex=0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] dec;
        dec = 5'h10;
        case (seg)
            SEG_G0[6:0]: dec = 5'h00;
            SEG_G1[6:0]: dec = 5'h01;
            SEG_G2[6:0]: dec = 5'h02;
            SEG_G3[6:0]: dec = 5'h03;
            SEG_G4[6:0]: dec = 5'h04;
            SEG_G5[6:0]: dec = 5'h05;
            SEG_G6[6:0]: dec = 5'h06;
            SEG_G7[6:0]: dec = 5'h07;
            SEG_G8[6:0]: dec = 5'h08;
            SEG_G9[6:0]: dec = 5'h09;
            SEG_GA[6:0]: dec = 5'h0A;
            SEG_GB[6:0]: dec = 5'h0B;
            SEG_GC[6:0]: dec = 5'h0C;
            SEG_GD[6:0]: dec = 5'h0D;
            SEG_GE[6:0]: dec = 5'h0E;
            SEG_GF[6:0]: dec = 5'h0F;
            default:     dec = 5'h10;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// Purpose: one active-low segment byte -> hex nibble plus no-match flag.
// Latency: combinational. Backpressure: none.
module seg7_glyph_dec
    import seg_serial_rx_pkg::*;
(
    input  logic [7:0] i_seg,
    output logic [3:0] o_hex,
    output logic       o_err
);

    logic [4:0] w_dec;
    logic       w_unused_dp;

    assign w_unused_dp = i_seg[7];
    assign w_dec       = seg_decode(i_seg[6:0]);
    assign o_hex       = w_dec[3:0];
    assign o_err       = w_dec[4];

endmodule

// File: rtl/seg_serial_rx.sv
// Purpose: oversampled receiver for the SEGCLK/SEGDT/SEGEN/SEGCLR link; latches and decodes 64-bit frames.
// Latency: frame_valid 1 clk after the LATCH cycle; optional BCD score (SEG_SCORE_BIN_EN) 4 clk after frame_valid.
// Backpressure: none; the link is free-running and frames with SEGEN low at LATCH are dropped.
module seg_serial_rx
    import seg_serial_rx_pkg::*;
#(
    parameter int FRAME_BITS  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  SEGCLK,
    input  logic                  SEGDT,
    input  logic                  SEGEN,
    input  logic                  SEGCLR,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic [31:0]           digits_hex,
    output logic [7:0]            digit_err,
    output logic                  busy
`ifdef SEG_SCORE_BIN_EN
    ,
    output logic [13:0]           score_bin,
    output logic                  score_valid
`endif
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dt_sync, r_en_sync, r_clr_sync;
    logic                   r_clk_prev;
    logic                   w_rise, w_dt, w_en, w_lclr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_clk_sync <= '0;
            r_dt_sync  <= '0;
            r_en_sync  <= '0;
            r_clr_sync <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], SEGCLK};
            r_dt_sync  <= {r_dt_sync[SYNC_STAGES-2:0], SEGDT};
            r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0], SEGEN};
            r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], SEGCLR};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
    assign w_dt   = r_dt_sync[SYNC_STAGES-1];
    assign w_en   = r_en_sync[SYNC_STAGES-1];
    assign w_lclr = r_clr_sync[SYNC_STAGES-1];

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [FRAME_BITS-1:0] r_sr, w_sr_nxt;
    logic                  w_latch;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_latch     = 1'b0;
        if (!w_lclr) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_sr_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_sr_nxt    = {r_sr[FRAME_BITS-2:0], w_dt};
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        w_sr_nxt  = {r_sr[FRAME_BITS-2:0], w_dt};
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_BIT) begin
                            w_state_nxt = ST_LATCH;
                        end
                    end
                end
                ST_LATCH: begin
                    w_latch = w_en;
                    // A rise landing here is the first bit of the next frame.
                    if (w_rise) begin
                        w_sr_nxt    = {r_sr[FRAME_BITS-2:0], w_dt};
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    logic [31:0] w_hex;
    logic [7:0]  w_err;

    for (genvar g = 0; g < 8; g++) begin : g_dec
        seg7_glyph_dec u_dec (
            .i_seg (r_sr[g*8 +: 8]),
            .o_hex (w_hex[g*4 +: 4]),
            .o_err (w_err[g])
        );
    end

    logic [FRAME_BITS-1:0] r_frame;
    logic [31:0]           r_digits;
    logic [7:0]            r_err;
    logic                  r_frame_vld;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_frame     <= '0;
            r_digits    <= '0;
            r_err       <= '0;
            r_frame_vld <= 1'b0;
        end else begin
            r_frame_vld <= w_latch;
            if (w_latch) begin
                r_frame  <= r_sr;
                r_digits <= w_hex;
                r_err    <= w_err;
            end
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_frame_vld;
    assign digits_hex  = r_digits;
    assign digit_err   = r_err;
    assign busy        = (r_state == ST_SHIFT);

`ifdef SEG_SCORE_BIN_EN
    logic [13:0] r_acc, r_score, w_acc_nxt;
    logic [1:0]  r_step, w_sel;
    logic        r_run, r_bad, r_score_vld, w_bad;
    logic [3:0]  w_nib;

    // Digits are consumed 3,2,1,0 so the accumulator builds the decimal value MSD first.
    assign w_sel     = 2'd3 - r_step;
    assign w_nib     = r_digits[{w_sel, 2'b00} +: 4];
    assign w_acc_nxt = r_acc * 14'd10 + {10'd0, w_nib};
    assign w_bad     = (|r_err[3:0]) | (r_digits[15:12] > 4'd9) | (r_digits[11:8] > 4'd9)
                     | (r_digits[7:4] > 4'd9) | (r_digits[3:0] > 4'd9);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_acc       <= '0;
            r_step      <= '0;
            r_run       <= 1'b0;
            r_bad       <= 1'b0;
            r_score     <= '0;
            r_score_vld <= 1'b0;
        end else begin
            r_score_vld <= 1'b0;
            if (r_frame_vld) begin
                r_acc  <= {10'd0, r_digits[15:12]};
                r_step <= 2'd1;
                r_run  <= 1'b1;
                r_bad  <= w_bad;
            end else if (r_run) begin
                r_acc  <= w_acc_nxt;
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) begin
                    r_run       <= 1'b0;
                    r_score     <= r_bad ? 14'h3FFF : w_acc_nxt;
                    r_score_vld <= 1'b1;
                end
            end
        end
    end

    assign score_bin   = r_score;
    assign score_valid = r_score_vld;
`endif

endmodule
